// File: rtl/immediate_generator_pipe_pkg.sv
// Shared types and encodings for the pipelined immediate generator.
// This package defines the format tags, the opcode and funct3 constants, and the buffer entry layout.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R    = 3'd6,
    FMT_SH   = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // The immediate is stored separately because its width depends on XLEN.
  typedef struct packed {
    imm_fmt_t    fmt;
    logic        illegal;
    logic [31:0] instr;
  } entry_meta_t;

endpackage

// File: rtl/immediate_generator_pipe_if.sv
// Handshake bundle for the immediate generator.
// It carries the upstream instruction stream and the downstream decoded result.
interface immediate_generator_pipe_if #(parameter int XLEN = 32);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  imm_fmt_t        fmt_out;
  logic            illegal;
  logic [31:0]     instr_out;

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, imm_out, fmt_out, illegal, instr_out
  );

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, imm_out, fmt_out, illegal, instr_out
  );
endinterface

// File: rtl/immediate_generator_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder.
// It produces the extended immediate, the format tag and an illegal-opcode flag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ZEXT_LOGIC = 0
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_t        o_fmt,
  output logic            o_illegal
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [31:0] w_val;
  logic        w_sext;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];

  // Every format is first assembled as a 32-bit value. It is then widened to XLEN either signed or unsigned.
  always_comb begin
    w_val     = '0;
    w_sext    = 1'b1;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (w_op)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_val = {{20{i_instr[31]}}, i_instr[31:20]};
        o_fmt = FMT_I;
      end
      OP_IMM: begin
        if (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA) begin
          w_val  = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
          w_sext = 1'b0;
          o_fmt  = FMT_SH;
        end else if (ZEXT_LOGIC != 0 && (w_f3 == F3_XOR || w_f3 == F3_OR || w_f3 == F3_AND)) begin
          w_val  = {20'b0, i_instr[31:20]};
          w_sext = 1'b0;
          o_fmt  = FMT_I;
        end else begin
          w_val = {{20{i_instr[31]}}, i_instr[31:20]};
          o_fmt = FMT_I;
        end
      end
      OP_STORE: begin
        w_val = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        o_fmt = FMT_S;
      end
      OP_BRANCH: begin
        w_val = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        o_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_val = {i_instr[31:12], 12'b0};
        o_fmt = FMT_U;
      end
      OP_JAL: begin
        w_val = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        o_fmt = FMT_J;
      end
      OP_REG: o_fmt = FMT_R;
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_imm = w_sext ? XLEN'($signed(w_val)) : XLEN'(w_val);

endmodule

// File: rtl/immediate_generator_pipe.sv
// Registered immediate generator behind a 2-entry skid buffer.
// Decode is combinational on the input side; this module holds only the buffer and the handshake.
module immediate_generator_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ZEXT_LOGIC = 0
) (
  input logic                        clk,
  input logic                        rst_n,
  input logic                        flush,
  immediate_generator_pipe_if.slave  bus
);

  logic [XLEN-1:0] w_dec_imm;
  imm_fmt_t        w_dec_fmt;
  logic            w_dec_illegal;
  logic            w_in_fire;
  logic            w_out_fire;

  occ_state_t      r_state;
  logic            r_out_valid;
  logic            r_in_ready;
  logic [XLEN-1:0] r_main_imm;
  entry_meta_t     r_main;
  logic [XLEN-1:0] r_skid_imm;
  entry_meta_t     r_skid;

  imm_decode_comb #(
    .XLEN       (XLEN),
    .ZEXT_LOGIC (ZEXT_LOGIC)
  ) u_decode (
    .i_instr   (bus.instruction),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_illegal)
  );

  // Flush blocks acceptance, so an instruction presented with it is dropped.
  assign w_in_fire  = bus.in_valid & r_in_ready & ~flush;
  assign w_out_fire = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_imm  <= '0;
      r_main      <= '0;
      r_skid_imm  <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= OCC_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            r_main_imm  <= w_dec_imm;
            r_main      <= '{fmt: w_dec_fmt, illegal: w_dec_illegal, instr: bus.instruction};
            r_out_valid <= 1'b1;
            r_state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_imm <= w_dec_imm;
            r_main     <= '{fmt: w_dec_fmt, illegal: w_dec_illegal, instr: bus.instruction};
          end else if (w_in_fire) begin
            r_skid_imm <= w_dec_imm;
            r_skid     <= '{fmt: w_dec_fmt, illegal: w_dec_illegal, instr: bus.instruction};
            r_in_ready <= 1'b0;
            r_state    <= OCC_FULL;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_out_fire) begin
            r_main_imm <= r_skid_imm;
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= OCC_ONE;
          end
        end
        default: begin
          r_state     <= OCC_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm_out   = r_main_imm;
  assign bus.fmt_out   = r_main.fmt;
  assign bus.illegal   = r_main.illegal;
  assign bus.instr_out = r_main.instr;

endmodule

// File: tb/tb_immediate_generator_pipe.sv
// Directed bench for immediate_generator_pipe.
// Three variants (32-bit, 32-bit with zero-extended logicals, 64-bit) share one stimulus stream.
module tb_immediate_generator_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        out_ready = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  immediate_generator_pipe_if #(.XLEN(32)) b32 ();
  immediate_generator_pipe_if #(.XLEN(32)) b32z ();
  immediate_generator_pipe_if #(.XLEN(64)) b64 ();

  assign b32.in_valid     = in_valid;
  assign b32.instruction  = instruction;
  assign b32.out_ready    = out_ready;
  assign b32z.in_valid    = in_valid;
  assign b32z.instruction = instruction;
  assign b32z.out_ready   = out_ready;
  assign b64.in_valid     = in_valid;
  assign b64.instruction  = instruction;
  assign b64.out_ready    = out_ready;

  immediate_generator_pipe #(.XLEN(32), .ZEXT_LOGIC(0)) dut32  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  immediate_generator_pipe #(.XLEN(32), .ZEXT_LOGIC(1)) dut32z (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32z));
  immediate_generator_pipe #(.XLEN(64), .ZEXT_LOGIC(0)) dut64  (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] e32;
    logic [31:0] e32z;
    logic [63:0] e64;
    imm_fmt_t    fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic init_vecs();
    vecs[0]  = '{32'hFEC29503, 32'hFFFFFFEC, 32'hFFFFFFEC, 64'hFFFFFFFFFFFFFFEC, FMT_I,    1'b0}; // lh -20
    vecs[1]  = '{32'hFE2088E3, 32'hFFFFFFF0, 32'hFFFFFFF0, 64'hFFFFFFFFFFFFFFF0, FMT_B,    1'b0}; // beq -16
    vecs[2]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J,    1'b0}; // jal -4
    vecs[3]  = '{32'hFFF2F513, 32'hFFFFFFFF, 32'h00000FFF, 64'hFFFFFFFFFFFFFFFF, FMT_I,    1'b0}; // andi -1
    vecs[4]  = '{32'h0FF2F513, 32'h000000FF, 32'h000000FF, 64'h00000000000000FF, FMT_I,    1'b0}; // andi 255
    vecs[5]  = '{32'h4030D093, 32'h00000003, 32'h00000003, 64'h0000000000000003, FMT_SH,   1'b0}; // srai 3
    vecs[6]  = '{32'h800000B7, 32'h80000000, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U,    1'b0}; // lui
    vecs[7]  = '{32'hFE20AC23, 32'hFFFFFFF8, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, FMT_S,    1'b0}; // sw -8
    vecs[8]  = '{32'h002081B3, 32'h00000000, 32'h00000000, 64'h0000000000000000, FMT_R,    1'b0}; // add
    vecs[9]  = '{32'h0000007F, 32'h00000000, 32'h00000000, 64'h0000000000000000, FMT_NONE, 1'b1}; // bad opcode
    vecs[10] = '{32'h80006093, 32'hFFFFF800, 32'h00000800, 64'hFFFFFFFFFFFFF800, FMT_I,    1'b0}; // ori -2048
    vecs[11] = '{32'h02109093, 32'h00000001, 32'h00000001, 64'h0000000000000021, FMT_SH,   1'b0}; // slli 33
    vecs[12] = '{32'h12345097, 32'h12345000, 32'h12345000, 64'h0000000012345000, FMT_U,    1'b0}; // auipc
  endtask

  // Present one instruction for one edge; the result sits in the main register on return.
  task automatic send_one(input logic [31:0] ins);
    @(posedge clk); #1;
    in_valid = 1'b1; instruction = ins; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", b32.out_valid); end
    total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", b32.in_ready); end
    total++; if (b64.imm_out !== 64'h0) begin bad++; $display("FAIL reset_imm got %h want 0", b64.imm_out); end
    total++; if (b32.fmt_out !== FMT_NONE) begin bad++; $display("FAIL reset_fmt got %0d want 0", b32.fmt_out); end
    total++; if (b32.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got %b want 0", b32.illegal); end
    total++; if (b32.instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", b32.instr_out); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 13; i++) begin
      send_one(vecs[i].instr);
      total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL dec_valid[%0d] got %b want 1", i, b32.out_valid); end
      total++; if (b32.imm_out !== vecs[i].e32) begin bad++; $display("FAIL dec_imm32[%0d] got %h want %h", i, b32.imm_out, vecs[i].e32); end
      total++; if (b32z.imm_out !== vecs[i].e32z) begin bad++; $display("FAIL dec_imm32z[%0d] got %h want %h", i, b32z.imm_out, vecs[i].e32z); end
      total++; if (b64.imm_out !== vecs[i].e64) begin bad++; $display("FAIL dec_imm64[%0d] got %h want %h", i, b64.imm_out, vecs[i].e64); end
      total++; if (b32.fmt_out !== vecs[i].fmt) begin bad++; $display("FAIL dec_fmt[%0d] got %0d want %0d", i, b32.fmt_out, vecs[i].fmt); end
      total++; if (b64.fmt_out !== vecs[i].fmt) begin bad++; $display("FAIL dec_fmt64[%0d] got %0d want %0d", i, b64.fmt_out, vecs[i].fmt); end
      total++; if (b32.illegal !== vecs[i].ill) begin bad++; $display("FAIL dec_illegal[%0d] got %b want %b", i, b32.illegal, vecs[i].ill); end
      total++; if (b32.instr_out !== vecs[i].instr) begin bad++; $display("FAIL dec_instr[%0d] got %h want %h", i, b32.instr_out, vecs[i].instr); end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; instruction = vecs[k].instr;
      @(posedge clk); #1;
      total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %b want 1", k, b32.out_valid); end
      total++; if (b32.instr_out !== vecs[k].instr) begin bad++; $display("FAIL b2b_instr[%0d] got %h want %h", k, b32.instr_out, vecs[k].instr); end
      total++; if (b64.imm_out !== vecs[k].e64) begin bad++; $display("FAIL b2b_imm64[%0d] got %h want %h", k, b64.imm_out, vecs[k].e64); end
      total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got %b want 1", k, b32.in_ready); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", b32.out_valid); end
  endtask

  task automatic test_stall();
    int idx = 0;
    int oidx = 0;
    int cyc = 0;
    @(posedge clk); #1;
    while (oidx < 6 && cyc < 40) begin
      out_ready   = (cyc >= 3);
      in_valid    = (idx < 6);
      instruction = vecs[(idx < 6) ? idx : 0].instr;
      if (cyc == 2) begin
        total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %b want 0", b32.in_ready); end
        total++; if (idx != 2) begin bad++; $display("FAIL stall_accepts got %0d want 2", idx); end
      end
      if (b32.out_valid === 1'b1) begin
        total++;
        if (b32.instr_out !== vecs[oidx].instr || b32.imm_out !== vecs[oidx].e32) begin
          bad++; $display("FAIL stall_order[%0d] got %h/%h want %h/%h", oidx, b32.instr_out, b32.imm_out, vecs[oidx].instr, vecs[oidx].e32);
        end
        if (out_ready) oidx++;
      end
      if (in_valid && b32.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (oidx != 6) begin bad++; $display("FAIL stall_timeout got %0d results want 6", oidx); end
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained got %b want 0", b32.out_valid); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; instruction = vecs[0].instr;
    @(posedge clk); #1;
    instruction = vecs[1].instr;
    @(posedge clk); #1;
    total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got in_ready %b want 0", b32.in_ready); end
    instruction = vecs[2].instr; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got %b want 0", b32.out_valid); end
    total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got %b want 1", b32.in_ready); end
    in_valid = 1'b1; instruction = vecs[3].instr;
    @(posedge clk); #1;
    total++; if (b32.instr_out !== vecs[3].instr) begin bad++; $display("FAIL flush_one_load got %h want %h", b32.instr_out, vecs[3].instr); end
    instruction = vecs[4].instr; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped[%0d] got %b want 0", k, b32.out_valid); end
      @(posedge clk); #1;
    end
    send_one(vecs[5].instr);
    total++; if (b32.instr_out !== vecs[5].instr) begin bad++; $display("FAIL flush_recover got %h want %h", b32.instr_out, vecs[5].instr); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; instruction = vecs[6].instr;
    @(posedge clk); #1;
    instruction = vecs[7].instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL areset_full got in_ready %b want 0", b32.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got %b want 0", b32.out_valid); end
    total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got %b want 1", b32.in_ready); end
    total++; if (b64.imm_out !== 64'h0) begin bad++; $display("FAIL areset_imm got %h want 0", b64.imm_out); end
    #2 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; instruction = vecs[1].instr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL areset_first_valid got %b want 1", b32.out_valid); end
    total++; if (b32.imm_out !== vecs[1].e32) begin bad++; $display("FAIL areset_first_imm got %h want %h", b32.imm_out, vecs[1].e32); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    init_vecs();
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/immediate_generator_pipe.md
# immediate_generator_pipe

Pipelined, parametrised successor of the combinational immediate generator. Decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-shamt) from a fetched instruction and registers the result behind a valid/ready handshake with a 2-entry skid buffer. It sits between the fetch/IF-ID stage and the ID/EX register. It adds optional zero-extension for logical immediates, format tagging, illegal-opcode flagging and a pipeline flush.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 or 64.
- `ZEXT_LOGIC`, 0, when 1, `andi`/`ori`/`xori` immediates are zero-extended; when 0, they are sign-extended (standard).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous; discards both buffered entries.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  block can accept an instruction.
- `instruction`  in  32  raw instruction word.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `imm_out`  out  XLEN  extended immediate.
- `fmt_out`  out  3  format tag, `imm_fmt_t`.
- `illegal`  out  1  opcode not recognised.
- `instr_out`  out  32  instruction carried alongside the result.

## Operation
- Opcode decode on `instruction[6:0]`:
  - `0000011`, `1100111` and `1110011` decode as I.
  - `0010011` decodes as I. The exception is funct3 `001`/`101`, which decodes as a shift: the immediate is shamt zero-extended. shamt is `[24:20]` for XLEN=32 and `[25:20]` for XLEN=64; funct7 is stripped.
  - `0100011` decodes as S.
  - `1100011` decodes as B, with bit 0 forced to 0.
  - `0110111` and `0010111` decode as U: `{instr[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - `1101111` decodes as J, with bit 0 forced to 0.
  - `0110011` decodes as R: imm=0, `fmt_out`=FMT_R, `illegal`=0.
  - Any other opcode: imm=0, `fmt_out`=FMT_NONE, `illegal`=1.
- When `ZEXT_LOGIC`=1 and the instruction is `0010011` with funct3 ∈ {100, 110, 111`}`, the 12-bit immediate is zero-extended. All other immediates sign-extend from the MSB of their encoded field.
- Buffer structure: one main register and one skid register, each holding {imm, fmt, illegal, instr}.
  - Transfer in: `in_valid & in_ready`.
  - Transfer out: `out_valid & out_ready`.
  - When the main register is occupied and not draining, new data lands in the skid register.
  - When the main register drains, the skid register moves into it.
- Occupancy states:
  - EMPTY (0 entries): `out_valid`=0.
  - ONE (1 entry): `out_valid`=1.
  - FULL (2 entries): `out_valid`=1, `in_ready`=0.
- State transitions:
  - EMPTY→ONE on in.
  - ONE→FULL on in without out.
  - ONE→EMPTY on out without in.
  - ONE→ONE on simultaneous in and out.
  - FULL→ONE on out. No input is accepted while FULL.
- `in_ready` is driven only from a register, as `!skid_valid`. It has no combinational path from `out_ready`.
- `flush`:
  - On the next edge, the block returns to EMPTY.
  - An `in_valid` presented in the same cycle is dropped, even if `in_ready`=1. Flush wins.
- Results are delivered strictly in acceptance order. No entry is lost or duplicated.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on `imm_out` after edge N.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- Output data is held stable while `out_valid=1 & out_ready=0`.
- Reset state: `out_valid`=0, `in_ready`=1, `imm_out`=0, `fmt_out`=FMT_NONE, `illegal`=0, `instr_out`=0, skid register empty.
- Reset asserted mid-stream clears all entries immediately; it does not wait for a clock edge.
- After reset releases, the first edge can accept an instruction.
- `out_ready` stalled for K cycles while streaming: exactly 2 instructions are accepted, then `in_ready`=0 from the following cycle.

## Structure
- Package `imm_pkg` contains:
  - `imm_fmt_t`: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_R=6, FMT_SH=7.
  - Opcode constants.
  - Funct3 constants for shift and logical operations.
- Sub-module `imm_decode_comb`: purely combinational decode, parametrised by XLEN and ZEXT_LOGIC.
- The top level holds only the 2-entry skid buffer and the handshake logic.

## Test plan
- `lh x10,-20(x5)`: instruction 0xFEC29503 → `imm_out`=0xFFFFFFEC, FMT_I, one cycle later. `beq` 0xFE2088E3 → 0xFFFFFFF0, FMT_B. `jal x0,-4` 0xFFDFF06F → 0xFFFFFFFC, FMT_J.
- `andi x10,x5,-1` (0xFFF2F513):
  - ZEXT_LOGIC=1 → 0x00000FFF.
  - ZEXT_LOGIC=0 → 0xFFFFFFFF.
  - `andi` 255 (0x0FF2F513) → 0x000000FF in both modes.
- `srai x1,x1,3` (0x4030D093) → 3, FMT_SH. `lui x1,0x80000` (0x800000B7):
  - XLEN=32 → 0x80000000.
  - XLEN=64 → 0xFFFFFFFF80000000.
- Stream 6 instructions with `out_ready` low for 3 cycles mid-stream:
  - `in_ready` falls after 2 accepts.
  - All 6 results appear in order, with no loss.
  - `out_ready` constant at 1 gives 1 result per cycle.
- Block FULL, then `flush` pulsed together with `in_valid`: next cycle `out_valid`=0, `in_ready`=1, and the flushed input never appears.
- Opcode 0x7F → `illegal`=1, imm=0. `rst_n` dropped while FULL → `out_valid`=0 before any clock edge.
